// File: rtl/noc_port_arbiter.sv
// Three-way round-robin arbiter that feeds a small output FIFO for a NoC port.
// Requesters 0/1 are the children and 2 is the parent; the FIFO holds 2 or 4 packets.
module noc_port_arbiter #(
    parameter int WIDTH = 47,
    parameter int NREQ  = 3,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       in_valid,
    input  logic [NREQ*WIDTH-1:0] in_data,
    output logic [NREQ-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [1:0]            last_grant,
    output logic [15:0]           pkt_count
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

    logic [1:0]       ptr_r;
    logic [1:0]       last_grant_r;
    logic [15:0]      pkt_count_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    logic [1:0]       cand1_s;
    logic [1:0]       cand2_s;
    logic [1:0]       win_s;
    logic             found_s;
    logic [1:0]       nxt_ptr_s;
    logic [WIDTH-1:0] win_data_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    function automatic logic sel_valid(input logic [2:0] v, input logic [1:0] idx);
        logic r;
        case (idx)
            2'd0:    r = v[0];
            2'd1:    r = v[1];
            2'd2:    r = v[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign full_s     = (count_r == FULL_C);
    assign out_valid  = ~rst & (count_r != {CW{1'b0}});
    assign out_data   = mem_r[rd_ptr_r];
    assign push_s     = |(in_valid & in_ready);
    assign pop_s      = out_valid & out_ready;
    assign last_grant = last_grant_r;
    assign pkt_count  = pkt_count_r;

    // Remaining search order after the round-robin pointer
    always_comb begin
        cand1_s = 2'd1;
        cand2_s = 2'd2;
        case (ptr_r)
            2'd0:    begin cand1_s = 2'd1; cand2_s = 2'd2; end
            2'd1:    begin cand1_s = 2'd2; cand2_s = 2'd0; end
            2'd2:    begin cand1_s = 2'd0; cand2_s = 2'd1; end
            default: begin cand1_s = 2'd1; cand2_s = 2'd2; end
        endcase
    end

    // Pick the first valid requester starting at the pointer
    always_comb begin
        win_s   = ptr_r;
        found_s = 1'b0;
        if (sel_valid(in_valid, ptr_r)) begin
            win_s   = ptr_r;
            found_s = 1'b1;
        end else if (sel_valid(in_valid, cand1_s)) begin
            win_s   = cand1_s;
            found_s = 1'b1;
        end else if (sel_valid(in_valid, cand2_s)) begin
            win_s   = cand2_s;
            found_s = 1'b1;
        end else begin
            win_s   = ptr_r;
            found_s = 1'b0;
        end
    end

    // Grant decode, next pointer and winner packet select
    always_comb begin
        in_ready   = 3'b000;
        nxt_ptr_s  = 2'd0;
        win_data_s = {WIDTH{1'b0}};
        case (win_s)
            2'd0:    begin nxt_ptr_s = 2'd1; win_data_s = in_data[0*WIDTH +: WIDTH]; end
            2'd1:    begin nxt_ptr_s = 2'd2; win_data_s = in_data[1*WIDTH +: WIDTH]; end
            2'd2:    begin nxt_ptr_s = 2'd0; win_data_s = in_data[2*WIDTH +: WIDTH]; end
            default: begin nxt_ptr_s = 2'd0; win_data_s = {WIDTH{1'b0}}; end
        endcase
        // No pass-through: a full FIFO refuses even if a pop happens this cycle
        if (!rst && found_s && !full_s) begin
            case (win_s)
                2'd0:    in_ready = 3'b001;
                2'd1:    in_ready = 3'b010;
                2'd2:    in_ready = 3'b100;
                default: in_ready = 3'b000;
            endcase
        end else begin
            in_ready = 3'b000;
        end
    end

    // Arbitration pointer, last grant and saturating packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r        <= 2'd0;
            last_grant_r <= 2'd0;
            pkt_count_r  <= 16'd0;
        end else if (push_s) begin
            ptr_r        <= nxt_ptr_s;
            last_grant_r <= win_s;
            if (pkt_count_r != 16'hFFFF) begin
                pkt_count_r <= pkt_count_r + 16'd1;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= win_data_s;
        end
    end

endmodule
